// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port SDRAM command arbiter with refresh scheduling and read timeout
module sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 390,
    parameter int REFRESH_URGENT   = 4,
    parameter int RD_TIMEOUT       = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_write,
    input  logic [1:0][25:0] req_addr,
    input  logic [1:0][15:0] req_wdata,
    output logic [1:0]       rsp_valid,
    output logic [15:0]      rsp_data,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_refresh,
    output logic [25:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_rvalid,
    output logic             ref_overflow,
    output logic             rd_timeout
);
    localparam int RC_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int RT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, REF_ISSUE} state_t;

    state_t          state;
    logic [RC_W-1:0] ref_cnt;
    logic [3:0]      pend_ref;
    logic [RT_W-1:0] rd_cnt;
    logic            last_grant;
    logic            owner;

    logic ref_wrap;
    logic ref_done;
    logic urgent;
    logic grant_port;
    logic grant_en;

    always_comb begin
        ref_wrap   = (ref_cnt == RC_W'(REFRESH_INTERVAL - 1));
        ref_done   = (state == REF_ISSUE) && mem_ready;
        urgent     = (pend_ref >= 4'(REFRESH_URGENT));
        grant_port = (&req_valid) ? ~last_grant : req_valid[1];
        grant_en   = reset_n && (state == IDLE) && !urgent && (|req_valid);
        req_ready  = 2'b00;
        if (grant_en) begin
            req_ready = grant_port ? 2'b10 : 2'b01;
        end
        rsp_valid = 2'b00;
        rsp_data  = '0;
        if (state == RD_WAIT) begin
            rsp_data = mem_rdata;
            if (mem_rvalid) begin
                rsp_valid = owner ? 2'b10 : 2'b01;
            end
        end
    end

    // A wrap and a completed refresh in the same cycle cancel out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt      <= '0;
            pend_ref     <= '0;
            ref_overflow <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + RC_W'(1);
            if (ref_wrap && !ref_done) begin
                if (pend_ref == 4'd8) begin
                    ref_overflow <= 1'b1;
                end else begin
                    pend_ref <= pend_ref + 4'd1;
                end
            end else if (ref_done && !ref_wrap) begin
                pend_ref <= pend_ref - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_cnt      <= '0;
            rd_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rd_cnt <= '0;
                    if (urgent) begin
                        state       <= REF_ISSUE;
                        mem_refresh <= 1'b1;
                    end else if (|req_valid) begin
                        state      <= ISSUE;
                        last_grant <= grant_port;
                        owner      <= grant_port;
                        mem_read   <= !req_write[grant_port];
                        mem_write  <= req_write[grant_port];
                        mem_addr   <= req_addr[grant_port];
                        mem_wdata  <= req_wdata[grant_port];
                    end else if (pend_ref != 4'd0) begin
                        state       <= REF_ISSUE;
                        mem_refresh <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= mem_write ? IDLE : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end else if (rd_cnt == RT_W'(RD_TIMEOUT - 1)) begin
                        rd_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + RT_W'(1);
                    end
                end
                REF_ISSUE: begin
                    if (mem_ready) begin
                        mem_refresh <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter
module tb_sdram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [1:0]       req_valid, req_ready, req_write, rsp_valid;
    logic [1:0][25:0] req_addr;
    logic [1:0][15:0] req_wdata;
    logic [15:0]      rsp_data, mem_wdata, mem_rdata;
    logic [25:0]      mem_addr;
    logic             mem_read, mem_write, mem_refresh, mem_ready, mem_rvalid;
    logic             ref_overflow, rd_timeout;

    logic             r_reset_n;
    logic [1:0]       r_req_valid, r_req_ready, r_req_write, r_rsp_valid;
    logic [1:0][25:0] r_req_addr;
    logic [1:0][15:0] r_req_wdata;
    logic [15:0]      r_rsp_data, r_mem_wdata, r_mem_rdata;
    logic [25:0]      r_mem_addr;
    logic             r_mem_read, r_mem_write, r_mem_refresh, r_mem_ready, r_mem_rvalid;
    logic             r_ref_overflow, r_rd_timeout;

    sdram_arbiter #(.RD_TIMEOUT(64)) u_main (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_refresh(mem_refresh), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .ref_overflow(ref_overflow), .rd_timeout(rd_timeout)
    );

    sdram_arbiter #(.REFRESH_INTERVAL(10)) u_ref (
        .clk(clk), .reset_n(r_reset_n), .req_valid(r_req_valid), .req_ready(r_req_ready),
        .req_write(r_req_write), .req_addr(r_req_addr), .req_wdata(r_req_wdata),
        .rsp_valid(r_rsp_valid), .rsp_data(r_rsp_data), .mem_read(r_mem_read),
        .mem_write(r_mem_write), .mem_refresh(r_mem_refresh), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_ready(r_mem_ready), .mem_rdata(r_mem_rdata),
        .mem_rvalid(r_mem_rvalid), .ref_overflow(r_ref_overflow), .rd_timeout(r_rd_timeout)
    );

    typedef struct {
        int          kind;
        int          port;
        logic [25:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_lat = 2;
    int   cd = 0;

    function automatic logic [15:0] rdata_of(input logic [25:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [25:0] addr_of(input int p, input int i);
        return 26'(32'h0100000 * (p + 1) + 32'h40 * i + 3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int port, input logic [25:0] addr, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    // Memory controller model for u_main: returns read data rd_lat cycles after acceptance.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_read && mem_ready) begin
                cd        = rd_lat;
                mem_rdata = rdata_of(mem_addr);
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) mem_rvalid = 1'b1;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((mem_read || mem_write) && mem_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_cmd", {mem_write, mem_read}, 0);
                end else begin
                    e = sb.pop_front();
                    check("cmd_kind", mem_write, e.kind);
                    check("cmd_addr", mem_addr, e.addr);
                    if (mem_write) check("cmd_wdata", mem_wdata, e.data);
                end
            end
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_port", rsp_valid, (e.kind == 2) ? ((e.port == 1) ? 2 : 1) : 0);
                    check("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic main_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_ref_periodic();
        r_reset_n   = 1'b0;
        r_req_valid = '0;
        r_mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ref_rst_outputs", {r_req_ready, r_mem_refresh, r_mem_read, r_mem_write, r_ref_overflow}, 0);
        r_reset_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            check("ref_periodic", r_mem_refresh, (n % 10 == 1) && (n > 10));
        end
    endtask

    task automatic run_ref_starve();
        r_reset_n      = 1'b0;
        r_mem_ready    = 1'b0;
        r_req_valid    = 2'b01;
        r_req_write    = 2'b01;
        r_req_addr[0]  = 26'h0ABCDEF;
        r_req_wdata[0] = 16'h1234;
        @(posedge clk);
        #1;
        r_reset_n = 1'b1;
        for (int n = 1; n <= 160; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) check("starve_write_held", {r_mem_write, r_mem_addr}, {1'b1, 26'h0ABCDEF});
            if (n == 89) check("ovf_before_9th_wrap", r_ref_overflow, 0);
            if (n == 90) check("ovf_at_9th_wrap", r_ref_overflow, 1);
            if (n == 95) r_mem_ready = 1'b1;
            if (n == 96) begin
                check("urgent_blocks_grant", {r_req_ready, r_mem_write}, 0);
                r_req_valid = '0;
            end
            if (n < 97) check("no_ref_while_issue", r_mem_refresh, 0);
            else check("ref_drain", r_mem_refresh, ((n <= 115) && (n % 2 == 1)) || ((n >= 120) && (n % 10 == 1)));
        end
        check("ovf_sticky", r_ref_overflow, 1);
    endtask

    task automatic run_round_robin();
        int i0 = 0;
        int i1 = 0;
        int budget = 0;
        logic [1:0] g;
        main_reset();
        rd_lat = 2;
        for (int i = 0; i < 4; i++) begin
            push(0, 0, addr_of(0, i), 0);
            push(2, 0, 0, rdata_of(addr_of(0, i)));
            push(0, 1, addr_of(1, i), 0);
            push(2, 1, 0, rdata_of(addr_of(1, i)));
        end
        req_write   = 2'b00;
        req_addr[0] = addr_of(0, 0);
        req_addr[1] = addr_of(1, 0);
        req_valid   = 2'b11;
        while ((i0 < 4 || i1 < 4) && budget < 200) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            budget++;
            if (g[0]) i0++;
            if (g[1]) i1++;
            req_valid   = {i1 < 4, i0 < 4};
            req_addr[0] = addr_of(0, i0);
            req_addr[1] = addr_of(1, i1);
        end
        check("rr_grants", i0 + i1, 8);
        repeat (6) @(posedge clk);
        #1;
        check("rr_sb_drained", sb.size(), 0);
    endtask

    task automatic run_write_stall();
        int pulses = 0;
        main_reset();
        mem_ready    = 1'b0;
        push(1, 1, 26'h1234567, 16'hBEEF);
        req_write    = 2'b10;
        req_addr[1]  = 26'h1234567;
        req_wdata[1] = 16'hBEEF;
        req_valid    = 2'b10;
        @(negedge clk);
        pulses += req_ready[1];
        @(posedge clk);
        #1;
        req_valid    = '0;
        req_addr[1]  = '0;
        req_wdata[1] = '0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) mem_ready = 1'b1;
            @(negedge clk);
            check("stall_cmd_stable", {mem_write, mem_read, mem_addr, mem_wdata}, {2'b10, 26'h1234567, 16'hBEEF});
            pulses += req_ready[1];
            @(posedge clk);
            #1;
        end
        check("stall_cmd_dropped", {mem_write, mem_read}, 0);
        check("stall_ready_pulses", pulses, 1);
        push(1, 0, 26'h0000777, 16'h4242);
        req_write    = 2'b01;
        req_addr[0]  = 26'h0000777;
        req_wdata[0] = 16'h4242;
        req_valid    = 2'b01;
        @(negedge clk);
        check("stall_back_to_idle", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_sb_drained", sb.size(), 0);
    endtask

    task automatic run_rd_timeout();
        int rsps = 0;
        main_reset();
        rd_lat = 80;
        push(0, 0, 26'h0345678, 0);
        req_write   = 2'b00;
        req_addr[0] = 26'h0345678;
        req_valid   = 2'b01;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (64) @(posedge clk);
        #1;
        check("rd_timeout_early", rd_timeout, 0);
        @(posedge clk);
        #1;
        check("rd_timeout_set", rd_timeout, 1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) rsps++;
        end
        check("late_rvalid_dropped", rsps, 0);
        check("rd_timeout_sticky", rd_timeout, 1);
        check("to_sb_drained", sb.size(), 0);
        rd_lat = 2;
    endtask

    task automatic run_reset_mid_read();
        logic [1:0] g;
        main_reset();
        rd_lat = 3;
        push(0, 0, 26'h0111111, 0);
        req_write   = 2'b00;
        req_addr[0] = 26'h0111111;
        req_valid   = 2'b01;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #2;
        reset_n      = 1'b0;
        req_write    = 2'b11;
        req_addr[0]  = 26'h0222222;
        req_addr[1]  = 26'h0333333;
        req_wdata[0] = 16'hA0A0;
        req_wdata[1] = 16'hB1B1;
        req_valid    = 2'b11;
        push(1, 0, 26'h0222222, 16'hA0A0);
        push(1, 1, 26'h0333333, 16'hB1B1);
        #1;
        check("async_rst_ctl", {req_ready, rsp_valid, mem_read, mem_write, mem_refresh, ref_overflow, rd_timeout}, 0);
        check("async_rst_data", {rsp_data, mem_addr, mem_wdata}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g = req_ready;
            if (c == 0) check("tie_after_reset", g, 2'b01);
            @(posedge clk);
            #1;
            req_valid = req_valid & ~g;
        end
        check("rst_sb_drained", sb.size(), 0);
        rd_lat = 2;
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = '0;
        req_write    = '0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_ready    = 1'b0;
        r_reset_n    = 1'b0;
        r_req_valid  = '0;
        r_req_write  = '0;
        r_req_addr   = '0;
        r_req_wdata  = '0;
        r_mem_ready  = 1'b0;
        r_mem_rvalid = 1'b0;
        r_mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("main_rst_ctl", {req_ready, rsp_valid, mem_read, mem_write, mem_refresh, ref_overflow, rd_timeout}, 0);
        check("main_rst_data", {rsp_data, mem_addr, mem_wdata}, 0);
        run_ref_periodic();
        run_ref_starve();
        run_round_robin();
        run_write_stall();
        run_rd_timeout();
        run_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 390, SHALL be the clk cycles between refresh requests (7.8 us at 50 MHz).
REQ-002 Parameter REFRESH_URGENT, default 4, SHALL be the pending-refresh count at which refresh pre-empts requesters.
REQ-003 Parameter RD_TIMEOUT, default 64, SHALL be the maximum clk cycles spent in RD_WAIT.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  [1:0]  per-port command valid; port 0 and port 1.
REQ-007 req_ready  out  [1:0]  per-port command accepted this cycle.
REQ-008 req_write  in  [1:0]  per-port: 1 = write, 0 = read.
REQ-009 req_addr  in  2x26  per-port address {chip, bank[1:0], row[12:0], col[9:0]}.
REQ-010 req_wdata  in  2x16  per-port write data.
REQ-011 rsp_valid  out  [1:0]  per-port read data valid.
REQ-012 rsp_data  out  16  read data, shared by both ports.
REQ-013 mem_read, mem_write, mem_refresh  out  1 each  command to the SDRAM controller; at most one is high in any cycle.
REQ-014 mem_addr  out  26, mem_wdata  out  16  command address and data.
REQ-015 mem_ready  in  1  the controller accepts the asserted command in this cycle.
REQ-016 mem_rdata  in  16, mem_rvalid  in  1  read return from the controller.
REQ-017 ref_overflow, rd_timeout  out  1 each  sticky error flags.

Function
REQ-018 States SHALL be IDLE, ISSUE, RD_WAIT, and REF_ISSUE.
REQ-019 Refresh counter SHALL count 0..REFRESH_INTERVAL-1 and wrap to 0; each wrap increments pend_ref (4 bits).
- pend_ref saturates at 8.
- A wrap while pend_ref=8 sets ref_overflow.
REQ-020 In IDLE, the block SHALL pick the next action in this priority order:
- pend_ref>=REFRESH_URGENT -> REF_ISSUE.
- Otherwise, any req_valid -> grant a port and go to ISSUE.
- Otherwise, pend_ref>0 -> REF_ISSUE.
- Otherwise, stay in IDLE.
REQ-021 Port grant SHALL be round-robin.
- With both ports valid, the port not equal to last_grant wins.
- With one port valid, that port wins.
- last_grant is updated to the granted port.
REQ-022 req_ready[n] SHALL be combinational and high only in IDLE in the cycle port n is granted.
- On grant, write, addr, wdata and port id are latched, so the requester may change its inputs the next cycle.
REQ-023 In ISSUE, the block SHALL assert mem_read or mem_write with the latched addr/wdata, held stable until mem_ready=1.
- On acceptance: write -> IDLE; read -> RD_WAIT.
REQ-024 In RD_WAIT, rsp_valid[owner] SHALL equal mem_rvalid and rsp_data SHALL equal mem_rdata, combinationally.
- mem_rvalid -> IDLE.
REQ-025 RD_WAIT SHALL count cycles from entry; reaching RD_TIMEOUT without mem_rvalid sets rd_timeout, returns to IDLE and drops any later mem_rvalid.
REQ-026 mem_rvalid outside RD_WAIT SHALL be ignored.
REQ-027 In REF_ISSUE, mem_refresh SHALL be held until mem_ready=1, then pend_ref decrements and the state returns to IDLE.
- A counter wrap in the same cycle leaves pend_ref unchanged.
REQ-028 Only one command SHALL be outstanding at a time; no grant occurs outside IDLE.
REQ-029 Minimum throughput SHALL be one command per 2 cycles when mem_ready=1.
REQ-030 ref_overflow and rd_timeout SHALL clear only on reset.

Reset
REQ-031 While reset_n=0, the following SHALL hold:
- State is IDLE.
- Refresh counter, pend_ref, RD_WAIT counter and all outputs are 0.
- last_grant is 1, so port 0 wins the first tie.
REQ-032 Reset asserted mid-command SHALL abandon the command at once; no response is delivered for it after release.
REQ-033 The refresh counter SHALL start counting on the first clk edge after reset_n rises.

Verification
REQ-034 Both ports valid continuously, mem_ready=1, reads returning 2 cycles after acceptance -> grants alternate 0,1,0,1; each rsp_valid goes only to its issuing port.
REQ-035 Port 1 write, addr 0x1234567, wdata 0xBEEF, mem_ready held low 5 cycles -> mem_write/addr/wdata stable for 6 cycles; one req_ready[1] pulse; return to IDLE after acceptance.
REQ-036 REFRESH_INTERVAL=10, ports idle -> mem_refresh asserted 1 cycle after each counter wrap; pend_ref returns to 0.
REQ-037 REFRESH_INTERVAL=10, port 0 saturating with mem_ready low -> pend_ref reaches 4; the next IDLE issues refresh ahead of port 0; starvation to 9 wraps sets ref_overflow.
REQ-038 Read accepted, mem_rvalid never arrives, RD_TIMEOUT=64 -> rd_timeout=1 after 64 cycles in RD_WAIT; a late mem_rvalid produces no rsp_valid.
REQ-039 reset_n pulsed low during RD_WAIT -> all outputs 0 immediately; after release, port 0 wins the first tie.
